// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// FSM state type and the default memory region base.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Default value required in req_addr[31:16] for an access to hit mem.
  localparam logic [15:0] MEM_ADDR_DEFAULT = 16'h1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/mem_lsu_lane.sv
// Combinational lane logic for the load/store unit.
//   size        : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   byte_off    : addr[1:0] of the access
//   load_signed : sign-extend sub-word loads
//   word_in     : containing memory word (read data or captured word)
//   store_data  : right-aligned store data
//   merged      : word_in with the target lane(s) replaced by store_data
//   load_data   : selected lane, right-aligned and extended
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  byte_off,
  input  logic        load_signed,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    merged    = word_in;
    load_data = word_in;
    lane8     = '0;
    lane16    = '0;
    case (size)
      SZ_BYTE: begin
        merged[{byte_off, 3'b000} +: 8] = store_data[7:0];
        lane8     = word_in[{byte_off, 3'b000} +: 8];
        load_data = {{24{load_signed & lane8[7]}}, lane8};
      end
      SZ_HALF: begin
        merged[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
        lane16    = word_in[{byte_off[1], 4'b0000} +: 16];
        load_data = {{16{load_signed & lane16[15]}}, lane16};
      end
      default: begin
        merged    = store_data;
        load_data = word_in;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit between the datapath and the word-addressed mem block.
// One access in flight; sub-word stores become read-modify-write.
//   clock, reset          : clock, synchronous active-low reset
//   req_*                 : valid/ready request (addr, size, we, signed, wdata)
//   resp_*                : valid/ready response (rdata, error)
//   mem_addr/wdata/we/re  : drive to mem; mem_rdata returned by mem
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter logic [15:0] MEM_ADDR      = MEM_ADDR_DEFAULT,
  parameter int unsigned NUM_WORDS_LOG = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_we,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned IDX_TOP = NUM_WORDS_LOG + 2;

  state_t      state, state_nx;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [31:0] lane_word;
  logic [31:0] merged;
  logic [31:0] load_data;

  // Address bits above the word index inside the region must be zero.
  always_comb begin
    req_err = (req_addr[31:16] != MEM_ADDR)
           || (|(req_addr[15:0] >> IDX_TOP))
           || (req_size == 2'b11)
           || (req_size == SZ_HALF && req_addr[0])
           || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  end

  // One lane block serves both directions: it extracts from the live read
  // data during READ and merges into the captured word during WRITE.
  assign lane_word = (state == ST_WRITE) ? word_q : mem_rdata;

  mem_lsu_lane u_lane (
    .size        (size_q),
    .byte_off    (addr_q[1:0]),
    .load_signed (signed_q),
    .word_in     (lane_word),
    .store_data  (wdata_q),
    .merged      (merged),
    .load_data   (load_data)
  );

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)
            state_nx = ST_RESP;
          else if (req_we && req_size == SZ_WORD)
            state_nx = ST_WRITE;
          else
            state_nx = ST_READ;
        end
      end
      ST_READ: begin
        mem_re   = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        state_nx = we_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_we    = reset;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = merged;
        state_nx  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            we_q     <= req_we;
            signed_q <= req_signed;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            rdata_q  <= '0;
          end
        end
        ST_READ: begin
          word_q <= mem_rdata;
          if (!we_q)
            rdata_q <= load_data;
        end
        ST_RESP: begin
          if (resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_error = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_we = 1'b0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  mem_lsu #(.MEM_ADDR(16'h1000), .NUM_WORDS_LOG(10)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_we(req_we), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Environment model of mem: read on negedge, write on posedge.
  logic [31:0] mem_arr [1024];
  logic        mem_filled = 1'b0;
  int unsigned we_pulses = 0;
  int unsigned re_pulses = 0;

  always @(posedge clock) begin
    if (!mem_filled) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] = init_word(i);
      mem_filled = 1'b1;
    end
    if (mem_we) begin
      mem_arr[mem_addr[11:2]] = mem_wdata;
      we_pulses++;
    end
  end

  always @(negedge clock) begin
    if (mem_re) begin
      mem_rdata = mem_arr[mem_addr[11:2]];
      re_pulses++;
    end
  end

  // Reference model state and rules.
  logic [31:0] ref_mem [1024];

  function automatic logic ref_err(logic [31:0] a, logic [1:0] sz);
    return (a[31:16] != 16'h1000) || (a[15:12] != 4'h0) || (sz == 2'd3)
        || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_mask(logic [1:0] sz);
    return (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [31:0] a,
                                           logic [1:0] sz, logic sg);
    logic [31:0] m, lane;
    int sh;
    m    = ref_mask(sz);
    sh   = (sz == 2'd2) ? 0 : int'(a[1:0]) * 8;
    lane = (w >> sh) & m;
    if (sz != 2'd2 && sg && ((lane & ((m >> 1) + 32'd1)) != 0))
      lane = lane | ~m;
    return lane;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request with resp_ready high; report per-cycle activity codes
  // (1 read, 2 write, 3 response) packed two bits per cycle.
  task automatic xact(input logic [31:0] a, input logic [1:0] sz, input logic w,
                      input logic sg, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e, output int lat,
                      output logic [15:0] seq);
    logic [1:0] code;
    @(negedge clock);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_we = w;
    req_signed = sg; req_wdata = wd; resp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    lat = 1;
    code = mem_re ? 2'd1 : mem_we ? 2'd2 : resp_valid ? 2'd3 : 2'd0;
    seq = {14'd0, code};
    while (!resp_valid && lat < 8) begin
      @(posedge clock); #1;
      lat++;
      code = mem_re ? 2'd1 : mem_we ? 2'd2 : resp_valid ? 2'd3 : 2'd0;
      seq = {seq[13:0], code};
    end
    rd = resp_rdata;
    e  = resp_error;
    if (!resp_valid) begin
      total++; bad++;
      $error("FAIL resp_timeout observed=%0d expected=resp_valid", lat);
    end
    @(posedge clock); #1;
    chk("post_hs_valid", 32'(resp_valid), 32'd0);
    chk("post_hs_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic w, input logic sg, input logic [31:0] wd,
                           output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_e, e;
    int          exp_lat, lat;
    logic [15:0] seq, exp_seq;
    int unsigned we0, re0, exp_we, exp_re;
    int          idx;
    idx   = int'(a[11:2]);
    exp_e = ref_err(a, sz);
    exp_rd = '0; exp_we = 0; exp_re = 0;
    if (exp_e) begin
      exp_lat = 1; exp_seq = 16'd3;
    end else if (w && sz == 2'd2) begin
      exp_lat = 2; exp_seq = 16'b1011; exp_we = 1;
    end else if (w) begin
      exp_lat = 3; exp_seq = 16'b011011; exp_we = 1; exp_re = 1;
    end else begin
      exp_lat = 2; exp_seq = 16'b0111; exp_re = 1;
      exp_rd = ref_load(ref_mem[idx], a, sz, sg);
    end
    we0 = we_pulses; re0 = re_pulses;
    xact(a, sz, w, sg, wd, rd, e, lat, seq);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_error"}, 32'(e), 32'(exp_e));
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_seq"}, 32'(seq), 32'(exp_seq));
    chk({tag, "_we_pulses"}, we_pulses - we0, exp_we);
    chk({tag, "_re_pulses"}, re_pulses - re0, exp_re);
    if (!exp_e && w) begin
      logic [31:0] m;
      int sh;
      m  = ref_mask(sz);
      sh = (sz == 2'd2) ? 0 : int'(a[1:0]) * 8;
      ref_mem[idx] = (ref_mem[idx] & ~(m << sh)) | ((wd & m) << sh);
    end
    chk({tag, "_memword"}, mem_arr[idx], ref_mem[idx]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, held, a, wd;
    logic [1:0]  sz;
    logic        w, sg;
    int unsigned we0;
    int          n;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    @(negedge clock); reset = 1'b1;

    // Word store then word load
    run_check("wst", 32'h1000_0010, 2'd2, 1'b1, 1'b0, 32'hDEAD_BEEF, rd);
    chk("wst_mem_const", mem_arr[4], 32'hDEAD_BEEF);
    run_check("wld", 32'h1000_0010, 2'd2, 1'b0, 1'b1, 32'h0, rd);
    chk("wld_const", rd, 32'hDEAD_BEEF);

    // Byte store merge
    run_check("pre", 32'h1000_0020, 2'd2, 1'b1, 1'b0, 32'h1122_3344, rd);
    run_check("bst", 32'h1000_0022, 2'd0, 1'b1, 1'b0, 32'h0000_00AA, rd);
    chk("bst_mem_const", mem_arr[8], 32'h11AA_3344);

    // Signed vs unsigned half loads
    run_check("hpre", 32'h1000_0030, 2'd2, 1'b1, 1'b0, 32'h8001_5555, rd);
    run_check("hld_s", 32'h1000_0032, 2'd1, 1'b0, 1'b1, 32'h0, rd);
    chk("hld_s_const", rd, 32'hFFFF_8001);
    run_check("hld_u", 32'h1000_0032, 2'd1, 1'b0, 1'b0, 32'h0, rd);
    chk("hld_u_const", rd, 32'h0000_8001);
    run_check("bld_s", 32'h1000_0033, 2'd0, 1'b0, 1'b1, 32'h0, rd);
    chk("bld_s_const", rd, 32'hFFFF_FF80);

    // Error cases
    run_check("err_half", 32'h1000_0001, 2'd1, 1'b1, 1'b0, 32'h1234_5678, rd);
    run_check("err_region", 32'h2000_0000, 2'd2, 1'b1, 1'b0, 32'h1234_5678, rd);
    run_check("err_size", 32'h1000_0040, 2'd3, 1'b0, 1'b0, 32'h0, rd);
    run_check("err_hibits", 32'h1000_1000, 2'd2, 1'b0, 1'b0, 32'h0, rd);
    run_check("err_word", 32'h1000_0042, 2'd2, 1'b1, 1'b0, 32'h0, rd);

    // Backpressure
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h1000_0010; req_size = 2'd2; req_we = 1'b0;
    req_signed = 1'b0; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 8) begin
      @(posedge clock); #1; n++;
    end
    chk("bp_lat", 32'(n), 32'd1);
    held = resp_rdata;
    chk("bp_data", held, 32'hDEAD_BEEF);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      chk("bp_valid_hold", 32'(resp_valid), 32'd1);
      chk("bp_data_hold", resp_rdata, 32'hDEAD_BEEF);
      chk("bp_err_hold", 32'(resp_error), 32'd0);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
    end
    @(negedge clock); resp_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_release_valid", 32'(resp_valid), 32'd0);
    chk("bp_release_ready", 32'(req_ready), 32'd1);

    // Reset during the WRITE cycle of a byte store
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h1000_0021; req_size = 2'd0; req_we = 1'b1;
    req_wdata = 32'h0000_005A; resp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("rw_read_cycle", 32'(mem_re), 32'd1);
    @(posedge clock); #1;
    chk("rw_write_cycle", 32'(mem_we), 32'd1);
    we0 = we_pulses;
    reset = 1'b0;
    #1;
    chk("rw_we_gated", 32'(mem_we), 32'd0);
    @(posedge clock); #1;
    chk("rw_no_write", we_pulses - we0, 32'd0);
    chk("rw_mem_kept", mem_arr[8], ref_mem[8]);
    chk("rw_req_ready", 32'(req_ready), 32'd1);
    chk("rw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rw_resp_rdata", resp_rdata, 32'd0);
    chk("rw_resp_error", 32'(resp_error), 32'd0);
    chk("rw_mem_outs", mem_addr | mem_wdata | {30'd0, mem_we, mem_re}, 32'd0);
    @(negedge clock); reset = 1'b1;
    run_check("rw_after", 32'h1000_0020, 2'd2, 1'b0, 1'b0, 32'h0, rd);
    chk("rw_after_const", rd, 32'h11AA_3344);

    // Randomized accesses against the reference model
    for (int t = 0; t < 40; t++) begin
      a  = {16'h1000, 4'h0, 10'(9'h40 + $urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      sz = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 7) == 0) a[31:16] = 16'($urandom);
      if ($urandom_range(0, 9) == 0) a[15:12] = 4'($urandom_range(1, 15));
      run_check("rnd", a, sz, w, sg, wd, rd);
    end
    for (int i = 'h40; i < 'h48; i++) chk("rnd_final_mem", mem_arr[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit between the processor datapath and the 4 KB word-addressed `mem` block. It accepts one byte, halfword or word access at a time over a valid/ready request channel. It performs region and alignment checks, and converts sub-word stores into a read-modify-write of the containing word. It returns sign- or zero-extended load data on a valid/ready response channel.

## Interface
Parameters:
- `MEM_ADDR`, 16'h1000: required value of `req_addr[31:16]`; any other value is an access error.
- `NUM_WORDS_LOG`, 10: word-index width forwarded to `mem`. It is used only for the error check on `req_addr[15:12]`, which must be zero.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low; low at a posedge resets the block.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_addr`  in  32  byte address.
- `req_size`  in  2  00 byte, 01 half, 10 word; 11 is an error.
- `req_we`  in  1  1 store, 0 load.
- `req_signed`  in  1  load sign-extension enable.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  misaligned, bad size or out of region.
- `mem_addr`  out  32  to `mem.addr_in`; word-aligned.
- `mem_wdata`  out  32  to `mem.data_in`.
- `mem_we`  out  1  to `mem.we_in`.
- `mem_re`  out  1  to `mem.re_in`.
- `mem_rdata`  in  32  from `mem.data_out`; valid at the posedge that ends a READ cycle.

## Operation
- States: IDLE, READ, WRITE, RESP.
- The request is captured at a posedge where `req_valid && req_ready`. Address, size, we, signed and wdata are registered.
- Error check runs at capture. Any of the following is an error:
  - `addr[31:16] != MEM_ADDR`
  - `addr[15:12] != 0`
  - size 11
  - half with `addr[0]`
  - word with `addr[1:0] != 0`
- State transitions:
  - Error: IDLE -> RESP with `resp_error=1`. `mem` is never touched.
  - Load: IDLE -> READ -> RESP.
  - Word store: IDLE -> WRITE -> RESP.
  - Byte or half store: IDLE -> READ -> WRITE -> RESP.
- READ: `mem_re=1`. The word is captured from `mem_rdata` at the closing posedge.
- WRITE:
  - `mem_we=1`.
  - Sub-word stores drive `mem_wdata` with the captured word, with the target lane(s) replaced by `req_wdata[7:0]` or `[15:0]`.
  - Word stores drive `mem_wdata = req_wdata`.
- Lane mapping is little-endian:
  - A byte at `addr[1:0]=k` occupies bits `[8k+7:8k]`.
  - A half at `addr[1]=h` occupies `[16h+15:16h]`.
- Load extraction:
  - Selects the lane and right-aligns it.
  - Bits above it are filled with the lane MSB if `req_signed`, else 0.
  - `req_signed` is ignored for word loads.
- `mem_addr = {addr[31:2], 2'b00}` in READ and WRITE, 0 otherwise.
- `mem_re` and `mem_we` are 0 outside READ and WRITE respectively.
- RESP:
  - `resp_valid=1`, held until `resp_ready`.
  - `resp_rdata` and `resp_error` are stable while held.
  - On handshake -> IDLE.

## Timing
- Reset (reset low at posedge):
  - state = IDLE, `resp_valid=0`, `resp_rdata=0`, `resp_error=0`, `req_ready=1`.
  - All `mem_*` outputs are 0; the captured registers are cleared.
- Reset in the middle of an access aborts it with no response.
- `mem_we` is gated by `reset` high, so a WRITE cycle coinciding with reset low performs no write.
- Latency from accept edge to `resp_valid` high, with `resp_ready` held high:
  - Error: 1 cycle.
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Throughput: one request in flight. `req_ready=0` from the accept edge until the response handshake edge. A new request cannot be accepted in the same cycle as the response handshake.
- `mem` reads on negedge. `mem_addr` must be driven from registered state only, never combinationally from `req_*`.

## Structure
- Package `mem_lsu_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the state enum;
  - the `MEM_ADDR` default.
- Sub-module `mem_lsu_lane` is purely combinational and handles lane merge (store) and lane extract plus extension (load) from size, `addr[1:0]` and `signed`.
- The top level holds the FSM, capture registers and `mem_*` drive.

## Test plan
- Word store then word load: store `0x10000010 <- 0xDEADBEEF`, then load it → `resp_rdata=0xDEADBEEF`, `resp_error=0`. Exactly one `mem_we` pulse.
- Byte store merge: preload word `0x11223344` at `0x10000020`, then store byte `0xAA` at `0x10000022` → memory word `0x11AA3344`. Sequence READ, WRITE, RESP at cycles 1, 2, 3.
- Signed vs unsigned half load of `0x8001xxxx` from `addr[1]=1`:
  - signed → `0xFFFF8001`;
  - unsigned → `0x00008001`.
- Errors, each giving `resp_error=1` at cycle 1 with `mem_re`/`mem_we` never asserted and memory unchanged:
  - half at `0x10000001`;
  - word at `0x20000000`;
  - size 11.
- Backpressure: hold `resp_ready=0` for 5 cycles → `resp_valid` and data stable, `req_ready=0`. Release → IDLE next cycle.
- Reset low during the WRITE cycle of a byte store → no memory change, all outputs at reset values, next request serviced normally.
